// File: rtl/grid_move_engine_if.sv
// Keycode/control inputs and committed-board outputs of the 2048 move engine.
// The slave side is the engine, the master side is whoever drives keys and reads the board.
interface grid_move_engine_if;
   logic [7:0]        keycode;
   logic              new_game;
   logic              load_en;
   logic [15:0][15:0] load_grid;
   logic [15:0][15:0] grid;
   logic [1:0]        win_lose;
   logic [19:0]       score;
   logic              busy;
   logic              move_done;

   modport master (
      output keycode, new_game, load_en, load_grid,
      input  grid, win_lose, score, busy, move_done
   );

   modport slave (
      input  keycode, new_game, load_en, load_grid,
      output grid, win_lose, score, busy, move_done
   );
endinterface

// File: rtl/grid_move_engine.sv
// 2048 game engine: slides/merges one line per clock on a private working grid,
// spawns a tile, evaluates win/lose and commits board, score and flags in one cycle.
module grid_move_engine #(
   parameter logic [15:0] WIN_VALUE = 16'd2048,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                Clk,
   input  logic                Reset,
   grid_move_engine_if.slave   bus,
   output logic [3:0]          state_dbg
);

   localparam logic [3:0] INIT0 = 4'd0;
   localparam logic [3:0] INIT1 = 4'd1;
   localparam logic [3:0] IDLE  = 4'd2;
   localparam logic [3:0] LINE0 = 4'd3;
   localparam logic [3:0] LINE1 = 4'd4;
   localparam logic [3:0] LINE2 = 4'd5;
   localparam logic [3:0] LINE3 = 4'd6;
   localparam logic [3:0] SPAWN = 4'd7;
   localparam logic [3:0] CHECK = 4'd8;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   typedef logic [3:0][15:0]  line_t;
   typedef logic [15:0][15:0] board_t;

   typedef struct packed {
      line_t       line;
      logic [16:0] add;
   } slide_t;

   logic [3:0]  state;
   logic [15:0] lfsr;
   logic [7:0]  prev_key;
   board_t      wg;
   logic [19:0] ws;
   logic [1:0]  dir;
   logic        moved;
   board_t      grid_q;
   logic [1:0]  win_lose_q;
   logic [19:0] score_q;
   logic        move_done_q;

   // Element j of line k for the latched direction; j = 0 is the edge tiles slide toward.
   function automatic logic [3:0] cell_idx(input logic [1:0] d, input logic [1:0] k,
                                           input logic [1:0] j);
      logic [3:0] idx;
      case (d)
         DIR_UP:   idx = {j, k};
         DIR_DOWN: idx = {~j, k};
         DIR_LEFT: idx = {k, j};
         default:  idx = {k, ~j};
      endcase
      return idx;
   endfunction

   function automatic slide_t slide(input line_t l);
      slide_t          r;
      line_t           c;
      logic [4:0][15:0] ce;
      logic [2:0]      n;
      logic [2:0]      o;
      logic            skip;
      c = '0;
      n = '0;
      for (int j = 0; j < 4; j++) begin
         if (l[j] != 16'd0) begin
            c[n[1:0]] = l[j];
            n = n + 3'd1;
         end
      end
      ce     = {16'd0, c};
      r.line = '0;
      r.add  = '0;
      o      = '0;
      skip   = 1'b0;
      // A merged result is written once and its partner skipped, so nothing merges twice.
      for (int j = 0; j < 4; j++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (ce[j] != 16'd0 && ce[j] == ce[j+1] && ce[j] != 16'h8000) begin
            r.line[o[1:0]] = {ce[j][14:0], 1'b0};
            r.add          = r.add + 17'({ce[j][14:0], 1'b0});
            skip           = 1'b1;
            o              = o + 3'd1;
         end else begin
            r.line[o[1:0]] = ce[j];
            o              = o + 3'd1;
         end
      end
      return r;
   endfunction

   logic        key_is_dir;
   logic [1:0]  key_dir;
   logic        key_event;

   always_comb begin
      key_is_dir = 1'b1;
      key_dir    = DIR_UP;
      case (bus.keycode)
         8'h1A:   key_dir = DIR_UP;
         8'h16:   key_dir = DIR_DOWN;
         8'h04:   key_dir = DIR_LEFT;
         8'h07:   key_dir = DIR_RIGHT;
         default: key_is_dir = 1'b0;
      endcase
   end

   assign key_event = key_is_dir && (bus.keycode != prev_key) && (state == IDLE);

   logic [1:0]  line_k;
   line_t       line_in;
   slide_t      res;
   logic        line_changed;
   logic [20:0] score_sum;
   logic [19:0] score_next;

   always_comb begin
      line_k  = 2'(state - LINE0);
      line_in = '0;
      for (int j = 0; j < 4; j++) begin
         line_in[j] = wg[cell_idx(dir, line_k, 2'(j))];
      end
      res          = slide(line_in);
      line_changed = (res.line != line_in);
      score_sum    = {1'b0, ws} + 21'(res.add);
      score_next   = (score_sum > 21'h0FFFFF) ? 20'hFFFFF : score_sum[19:0];
   end

   // Shared spawn logic: INIT0 spawns onto an empty board, INIT1/SPAWN onto wg.
   board_t      spawn_src;
   board_t      spawned;
   logic        spawn_found;
   logic [3:0]  spawn_pos;
   logic [15:0] spawn_val;

   always_comb begin
      spawn_src   = (state == INIT0) ? '0 : wg;
      spawn_found = 1'b0;
      spawn_pos   = lfsr[3:0];
      spawn_val   = (lfsr[7:4] == 4'd0) ? 16'd4 : 16'd2;
      for (int i = 15; i >= 0; i--) begin
         if (spawn_src[lfsr[3:0] + 4'(i)] == 16'd0) begin
            spawn_found = 1'b1;
            spawn_pos   = lfsr[3:0] + 4'(i);
         end
      end
      spawned = spawn_src;
      if (spawn_found) begin
         spawned[spawn_pos] = spawn_val;
      end
   end

   logic       any_win;
   logic       any_empty;
   logic       any_pair;
   logic [1:0] verdict;

   always_comb begin
      any_win   = 1'b0;
      any_empty = 1'b0;
      any_pair  = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (wg[r*4+c] >= WIN_VALUE) any_win = 1'b1;
            if (wg[r*4+c] == 16'd0) any_empty = 1'b1;
            if (c < 3 && wg[r*4+c] == wg[4'(r*4+c+1)]) any_pair = 1'b1;
            if (r < 3 && wg[r*4+c] == wg[4'(r*4+c+4)]) any_pair = 1'b1;
         end
      end
      if (any_win)                   verdict = 2'b01;
      else if (!any_empty && !any_pair) verdict = 2'b10;
      else                           verdict = 2'b00;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= INIT0;
         lfsr        <= LFSR_SEED;
         prev_key    <= 8'd0;
         wg          <= '0;
         ws          <= 20'd0;
         dir         <= DIR_UP;
         moved       <= 1'b0;
         grid_q      <= '0;
         win_lose_q  <= 2'b00;
         score_q     <= 20'd0;
         move_done_q <= 1'b0;
      end else begin
         lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         prev_key    <= bus.keycode;
         move_done_q <= 1'b0;
         case (state)
            INIT0: begin
               wg    <= spawned;
               ws    <= 20'd0;
               state <= INIT1;
            end
            INIT1: begin
               wg         <= spawned;
               grid_q     <= spawned;
               score_q    <= 20'd0;
               win_lose_q <= 2'b00;
               state      <= IDLE;
            end
            IDLE: begin
               if (bus.new_game) begin
                  state <= INIT0;
               end else if (bus.load_en) begin
                  wg     <= bus.load_grid;
                  grid_q <= bus.load_grid;
               end else if (key_event && win_lose_q == 2'b00) begin
                  dir   <= key_dir;
                  moved <= 1'b0;
                  state <= LINE0;
               end
            end
            LINE0, LINE1, LINE2, LINE3: begin
               for (int j = 0; j < 4; j++) begin
                  wg[cell_idx(dir, line_k, 2'(j))] <= res.line[j];
               end
               ws <= score_next;
               if (line_changed) moved <= 1'b1;
               state <= (state == LINE3) ? SPAWN : state + 4'd1;
            end
            SPAWN: begin
               if (moved) wg <= spawned;
               state <= CHECK;
            end
            CHECK: begin
               grid_q      <= wg;
               score_q     <= ws;
               win_lose_q  <= verdict;
               move_done_q <= 1'b1;
               state       <= IDLE;
            end
            default: state <= INIT0;
         endcase
      end
   end

   assign bus.grid      = grid_q;
   assign bus.win_lose  = win_lose_q;
   assign bus.score     = score_q;
   assign bus.busy      = (state != IDLE);
   assign bus.move_done = move_done_q;
   assign state_dbg     = state;

endmodule

// File: tb/tb_grid_move_engine.sv
// Directed bench for grid_move_engine: init, slides/merges in all directions, win/lose,
// key-edge detection and mid-move reset, with hand-computed expectations.
module tb_grid_move_engine;
   logic       Clk;
   logic       Reset;
   logic [3:0] state_dbg;
   int         n_checks;
   int         n_errors;
   logic [15:0] exp_q[$];
   logic [19:0] exp_score;

   grid_move_engine_if bus ();

   grid_move_engine dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int count_nz(input logic [15:0] mask);
      int n = 0;
      for (int i = 0; i < 16; i++) if (!mask[i] && bus.grid[i] != 16'd0) n++;
      return n;
   endfunction

   function automatic int count_bad(input logic [15:0] mask);
      int n = 0;
      for (int i = 0; i < 16; i++)
         if (!mask[i] && bus.grid[i] != 16'd0 && bus.grid[i] != 16'd2 && bus.grid[i] != 16'd4) n++;
      return n;
   endfunction

   // driver tasks
   task automatic do_load(input logic [15:0][15:0] g);
      bus.load_grid = g;
      bus.load_en   = 1'b1;
      tick();
      bus.load_en   = 1'b0;
      for (int i = 0; i < 16; i++) exp_q.push_back(g[i]);
      for (int i = 0; i < 16; i++) check($sformatf("load_cell%0d", i), 32'(bus.grid[i]), 32'(exp_q.pop_front()));
   endtask

   task automatic do_move(input logic [7:0] key, input string tag);
      int busy_n = 0;
      int md_n   = 0;
      bus.keycode = key;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.busy) busy_n++;
         if (bus.move_done) md_n++;
      end
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'd6);
      check({tag, "_early_done"}, 32'(md_n), 32'd0);
      tick();
      check({tag, "_done"}, 32'(bus.move_done), 32'd1);
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
      bus.keycode = 8'h00;
      tick();
      check({tag, "_done_pulse"}, 32'(bus.move_done), 32'd0);
   endtask

   task automatic do_new_game(input string tag);
      bus.new_game = 1'b1;
      tick();
      bus.new_game = 1'b0;
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      tick();
      tick();
      exp_score = 20'd0;
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
      check({tag, "_wl"}, 32'(bus.win_lose), 32'd0);
      check({tag, "_score"}, 32'(bus.score), 32'(exp_score));
      check({tag, "_tiles"}, 32'(count_nz(16'h0000)), 32'd2);
      check({tag, "_tile_vals"}, 32'(count_bad(16'h0000)), 32'd0);
   endtask

   task automatic ignored_key(input logic [7:0] key, input string tag);
      int busy_n = 0;
      bus.keycode = key;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.busy) busy_n++;
      end
      check(tag, 32'(busy_n), 32'd0);
      bus.keycode = 8'h00;
      tick();
   endtask

   initial begin
      logic [15:0][15:0] b;
      int md_n;
      int busy_n;
      n_checks     = 0;
      n_errors     = 0;
      exp_score    = 20'd0;
      bus.keycode  = 8'h00;
      bus.new_game = 1'b0;
      bus.load_en  = 1'b0;
      bus.load_grid = '0;
      Reset        = 1'b1;
      tick();
      tick();
      check("rst_busy", 32'(bus.busy), 32'd1);
      check("rst_grid", 32'(count_nz(16'h0000)), 32'd0);
      check("rst_score", 32'(bus.score), 32'd0);
      check("rst_wl", 32'(bus.win_lose), 32'd0);
      check("rst_done", 32'(bus.move_done), 32'd0);
      Reset = 1'b0;
      tick();
      check("init_c1_busy", 32'(bus.busy), 32'd1);
      check("init_c1_grid", 32'(count_nz(16'h0000)), 32'd0);
      tick();
      check("init_c2_busy", 32'(bus.busy), 32'd0);
      check("init_tiles", 32'(count_nz(16'h0000)), 32'd2);
      check("init_tile_vals", 32'(count_bad(16'h0000)), 32'd0);
      check("init_score", 32'(bus.score), 32'd0);
      check("init_wl", 32'(bus.win_lose), 32'd0);

      // left: [2,2,2,2] -> [4,4,0,0]
      b = '0;
      b[0] = 16'd2; b[1] = 16'd2; b[2] = 16'd2; b[3] = 16'd2;
      do_load(b);
      do_move(8'h04, "left4");
      exp_score = 20'd8;
      check("left4_c0", 32'(bus.grid[0]), 32'd4);
      check("left4_c1", 32'(bus.grid[1]), 32'd4);
      check("left4_spawn", 32'(count_nz(16'h0003)), 32'd1);
      check("left4_spawn_val", 32'(count_bad(16'h0003)), 32'd0);
      check("left4_score", 32'(bus.score), 32'(exp_score));
      check("left4_wl", 32'(bus.win_lose), 32'd0);

      // right: row1 [2,2,2,0] -> [0,0,2,4]
      b = '0;
      b[4] = 16'd2; b[5] = 16'd2; b[6] = 16'd2;
      do_load(b);
      do_move(8'h07, "right");
      exp_score = 20'd12;
      check("right_c7", 32'(bus.grid[7]), 32'd4);
      check("right_c6", 32'(bus.grid[6]), 32'd2);
      check("right_tiles", 32'(count_nz(16'h0000)), 32'd3);
      check("right_score", 32'(bus.score), 32'(exp_score));

      // down: column0 top..bottom [4,0,4,8] -> bottom 8, then 8
      b = '0;
      b[0] = 16'd4; b[8] = 16'd4; b[12] = 16'd8;
      do_load(b);
      do_move(8'h16, "down");
      exp_score = 20'd20;
      check("down_c12", 32'(bus.grid[12]), 32'd8);
      check("down_c8", 32'(bus.grid[8]), 32'd8);
      check("down_tiles", 32'(count_nz(16'h0000)), 32'd3);
      check("down_score", 32'(bus.score), 32'(exp_score));

      // full board without pairs: no change, no spawn, lost
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            b[r*4+c] = 16'(2 << (r + c));
      do_load(b);
      do_move(8'h04, "lose");
      for (int i = 0; i < 16; i++) exp_q.push_back(b[i]);
      for (int i = 0; i < 16; i++) check($sformatf("lose_cell%0d", i), 32'(bus.grid[i]), 32'(exp_q.pop_front()));
      check("lose_score", 32'(bus.score), 32'(exp_score));
      check("lose_wl", 32'(bus.win_lose), 32'd2);
      ignored_key(8'h07, "lose_key_ignored");
      do_new_game("ng1");

      // win: 1024+1024
      b = '0;
      b[0] = 16'd1024; b[1] = 16'd1024;
      do_load(b);
      do_move(8'h04, "win");
      check("win_c0", 32'(bus.grid[0]), 32'd2048);
      check("win_wl", 32'(bus.win_lose), 32'd1);
      check("win_score", 32'(bus.score), 32'd2048);
      check("win_tiles", 32'(count_nz(16'h0000)), 32'd2);
      ignored_key(8'h07, "win_key_ignored");
      do_new_game("ng2");

      // 32768 never merges
      b = '0;
      b[0] = 16'h8000; b[4] = 16'h8000;
      do_load(b);
      do_move(8'h16, "max");
      check("max_c12", 32'(bus.grid[12]), 32'h8000);
      check("max_c8", 32'(bus.grid[8]), 32'h8000);
      check("max_tiles", 32'(count_nz(16'h0000)), 32'd3);
      check("max_score", 32'(bus.score), 32'd0);
      check("max_wl", 32'(bus.win_lose), 32'd1);
      do_new_game("ng3");

      // held key moves once; direct direction change moves again; non-direction key ignored
      b = '0;
      b[12] = 16'd2;
      do_load(b);
      bus.keycode = 8'h1A;
      md_n = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus.move_done) md_n++;
      end
      check("hold_moves", 32'(md_n), 32'd1);
      check("hold_c0", 32'(bus.grid[0]), 32'd2);
      bus.keycode = 8'h07;
      md_n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.move_done) md_n++;
      end
      check("change_moves", 32'(md_n), 32'd1);
      bus.keycode = 8'h00;
      tick();
      bus.keycode = 8'h2C;
      md_n = 0;
      busy_n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.move_done) md_n++;
         if (bus.busy) busy_n++;
      end
      check("space_moves", 32'(md_n), 32'd0);
      check("space_busy", 32'(busy_n), 32'd0);

      // reset in T+3 of a move
      b = '0;
      b[0] = 16'd2; b[1] = 16'd2;
      do_load(b);
      bus.keycode = 8'h04;
      tick();
      tick();
      tick();
      Reset = 1'b1;
      tick();
      check("mid_rst_grid", 32'(count_nz(16'h0000)), 32'd0);
      check("mid_rst_score", 32'(bus.score), 32'd0);
      check("mid_rst_busy", 32'(bus.busy), 32'd1);
      check("mid_rst_done", 32'(bus.move_done), 32'd0);
      md_n = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.move_done) md_n++;
      end
      check("mid_rst_no_done", 32'(md_n), 32'd0);
      bus.keycode = 8'h00;
      Reset = 1'b0;
      tick();
      tick();
      check("post_rst_tiles", 32'(count_nz(16'h0000)), 32'd2);
      check("post_rst_idle", 32'(bus.busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/grid_move_engine.md
# grid_move_engine

Hardware 2048 game-logic engine that sits directly upstream of `game_image_mapper`. It consumes the USB keycode and produces the 16-cell tile grid and the win/lose flags that the mapper renders. Each move slides and merges the grid one line per clock, spawns a random tile, checks for win/lose, and then commits the whole grid to the outputs in one cycle. Because of that single-cycle commit, the renderer never sees a half-updated board.

## Interface
- `WIN_VALUE`, 16'd2048, tile value that sets win.
- `LFSR_SEED`, 16'hACE1, LFSR reset value (must be nonzero).
- `Clk`  in  1  system clock, 50 MHz.
- `Reset`  in  1  reset; synchronous, active-high.
- `keycode`  in  8  USB HID keycode: 0x1A = up (W), 0x16 = down (S), 0x04 = left (A), 0x07 = right (D); all other values are ignored.
- `new_game`  in  1  level; sampled in IDLE only.
- `load_en`  in  1  test preload strobe; sampled in IDLE only.
- `load_grid`  in  16×16  preload values.
- `grid`  out  16×16  committed board; index r*4+c, r0 = top row, c0 = left column, 0 = empty.
- `win_lose`  out  2  00 = playing, 01 = won, 10 = lost.
- `score`  out  20  sum of merged tile values; saturates at 0xFFFFF.
- `busy`  out  1  high whenever state ≠ IDLE.
- `move_done`  out  1  one-cycle pulse when a move commit becomes visible.

## Operation
- Internal state:
  - working grid `wg[16]`, separate from the output `grid`.
  - `prev_key` register, updated every cycle including while busy.
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle.
- Key event: `keycode` is a direction code, `keycode != prev_key`, and state is IDLE. A held key therefore moves once; a direct change from one direction to another counts as a new event.
- States:
  - INIT0: clear `wg`, `score` and `win_lose`; spawn one tile.
  - INIT1: spawn one tile; commit; go to IDLE.
  - IDLE: priority order is `new_game` → INIT0, then `load_en` → copy `load_grid` into `wg` and `grid` next cycle (`score` and `win_lose` unchanged), then key event with `win_lose == 00` → latch direction, clear `moved`, go to LINE0. Key events while `win_lose != 00` are ignored.
  - LINE0–3: process line k. Element j of line k is:
    - up: `wg[j*4+k]`
    - down: `wg[(3-j)*4+k]`
    - left: `wg[k*4+j]`
    - right: `wg[k*4+3-j]`
  - Slide/merge rule:
    - Compress nonzero tiles toward j = 0.
    - Merge equal adjacent pairs scanning from j = 0; each tile merges at most once.
    - A tile of value 32768 never merges.
    - Examples: [2,2,2,2] → [4,4,0,0]; [2,2,4,0] → [4,4,0,0]; [4,0,4,8] → [8,8,0,0]; [2,2,2,0] → [4,2,0,0].
  - During each LINE state: add merged values to `score`, and set `moved` if the line changed.
  - SPAWN, taken only if `moved`:
    - Take p = `lfsr[3:0]`; scan p, p+1, … mod 16 and use the first empty cell.
    - The new tile is 4 if `lfsr[7:4] == 0`, else 2.
    - If `moved` is clear, `wg` is untouched.
  - CHECK:
    - Set `win_lose = 01` if any cell ≥ `WIN_VALUE`.
    - Otherwise set 10 if there is no empty cell and no horizontally or vertically adjacent equal pair.
    - Otherwise 00.
    - Copy `wg` to `grid`; go to IDLE.
- The spawn helper used by INIT and SPAWN is the same logic. INIT always spawns, even if the board is empty.

## Timing
- Reset (synchronous) values:
  - `grid` all 0, `win_lose` 00, `score` 0, `move_done` 0, `busy` 1.
  - State INIT0, LFSR = `LFSR_SEED`, `prev_key` = 0.
- After Reset is released:
  - INIT0 and INIT1 occupy 2 cycles.
  - `grid` shows two tiles on the 3rd cycle, at which point `busy` = 0.
- Key event seen in IDLE in cycle T:
  - LINE0..3 run in T+1..T+4, SPAWN in T+5, CHECK in T+6.
  - `grid`, `score` and `win_lose` update together and are visible in T+7.
  - `move_done` is high in T+7 only.
  - `busy` is high T+1..T+6.
- Outputs update only at commit (INIT1, CHECK) or on a load, always in a single cycle. Intermediate LINE results are never exposed.
- Score saturation: a running value plus an addend above 0xFFFFF clamps to 0xFFFFF.
- Reset asserted mid-move abandons the move; the next cycle shows reset values.
- `new_game`, `load_en` and key events are ignored while busy. `prev_key` is still tracked during busy, so a key held throughout a move does not repeat afterward.
- A move that changes nothing still runs the full 7-cycle sequence, skips the spawn, and still pulses `move_done`.

## Test plan
- Reset, then idle: in cycle 3, exactly 2 cells are nonzero, each 2 or 4; `score` = 0; `win_lose` = 00; `busy` drops at cycle 3.
- Load row 0 = [2,2,2,2], rest 0; keycode 0x04 → 7 cycles later, `grid[0..1]` = 4,4, exactly one new 2/4 tile elsewhere, `score` = 8, single `move_done` pulse.
- Load rows [2,4,8,16], [4,8,16,32], [8,16,32,64], [16,32,64,128]; key 0x04 → `grid` unchanged, no spawn, `score` unchanged, `win_lose` = 10 (full board, no adjacent equal pair).
- Load `grid[0..1]` = 1024,1024; key 0x04 → `grid[0]` = 2048, `win_lose` = 01; a following 0x07 is ignored (no `busy`); `new_game` → INIT, `win_lose` = 00.
- Hold 0x1A for 100 cycles → exactly one `move_done`; change 0x1A → 0x07 with no release → second move; 0x00 → 0x2C → no move.
- Assert Reset in T+3 of a move → next cycle `grid` = 0, `score` = 0, `busy` = 1, no `move_done`.
